// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared constants and grant encoding for the writeback arbiter.
// Revision    : 1.0
// ============================================================================
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_W = 5;

   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_ALU  = 2'd1,
      GRANT_MEM  = 2'd2
   } grant_t;

endpackage
`default_nettype wire

// File: rtl/writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter_if
// Description : ALU/load producer handshakes plus register-file write port.
// Revision    : 1.0
// ============================================================================
interface writeback_arbiter_if #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 4
);
   logic                          alu_valid;
   logic                          alu_ready;
   logic [ADDR_W-1:0]             alu_rd;
   logic [DATA_W-1:0]             alu_data;
   logic                          mem_valid;
   logic                          mem_ready;
   logic [ADDR_W-1:0]             mem_rd;
   logic [DATA_W-1:0]             mem_data;
   logic                          wr_en;
   logic [ADDR_W-1:0]             wr_addr;
   logic [DATA_W-1:0]             wr_data;
   logic [(2**ADDR_W)-1:0]        pending_mask;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;

   modport master (
      output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
      input  alu_ready, mem_ready, wr_en, wr_addr, wr_data, pending_mask, fifo_count
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
      output alu_ready, mem_ready, wr_en, wr_addr, wr_data, pending_mask, fifo_count
   );
endinterface
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : In-order load-result FIFO exposing per-entry valid/rd vectors.
// Revision    : 1.0
// ============================================================================
module wb_fifo #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
) (
   input  wire logic                      clk,
   input  wire logic                      reset,
   input  wire logic                      push,
   input  wire logic [ADDR_W-1:0]         push_rd,
   input  wire logic [DATA_W-1:0]         push_data,
   input  wire logic                      pop,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH):0]         count,
   output logic [ADDR_W-1:0]              head_rd,
   output logic [DATA_W-1:0]              head_data,
   output logic [DEPTH-1:0]               entry_valid,
   output logic [DEPTH*ADDR_W-1:0]        entry_rd
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] r_mem_rd   [DEPTH];
   logic [DATA_W-1:0] r_mem_data [DEPTH];
   logic [DEPTH-1:0]  r_valid;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_push;
   logic              w_pop;

   assign full  = (r_count == CNT_W'(DEPTH));
   assign empty = (r_count == '0);
   // A full FIFO refuses a push even when a pop frees a slot this cycle.
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;

   assign count       = r_count;
   assign head_rd     = r_mem_rd[r_rd_ptr];
   assign head_data   = r_mem_data[r_rd_ptr];
   assign entry_valid = r_valid;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign entry_rd[gi*ADDR_W +: ADDR_W] = r_mem_rd[gi];
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_rd[r_wr_ptr]   <= push_rd;
         r_mem_data[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_valid[r_wr_ptr] <= 1'b1;
            r_wr_ptr          <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_valid[r_rd_ptr] <= 1'b0;
            r_rd_ptr          <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Serializes ALU and buffered load results onto one RF write
//               port. Define WB_R0_DISCARD_EN to suppress writes to r0.
// Revision    : 1.0
// ============================================================================
module writeback_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_W       = WB_DATA_W,
   parameter int ADDR_W       = WB_ADDR_W,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  wire logic           clk,
   input  wire logic           reset,
   writeback_arbiter_if.slave  bus
);
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [STARVE_W-1:0] c_starve_max = STARVE_W'(STARVE_LIMIT);

   logic                           w_full;
   logic                           w_empty;
   logic [$clog2(FIFO_DEPTH):0]    w_count;
   logic [ADDR_W-1:0]              w_head_rd;
   logic [DATA_W-1:0]              w_head_data;
   logic [FIFO_DEPTH-1:0]          w_entry_valid;
   logic [FIFO_DEPTH*ADDR_W-1:0]   w_entry_rd;
   logic                           w_fifo_ne;
   logic                           w_starved;
   logic                           w_alu_ready;
   logic                           w_mem_ready;
   logic                           w_push;
   logic                           w_pop;
   logic                           w_write;
   grant_t                         w_grant;
   logic [ADDR_W-1:0]              w_sel_rd;
   logic [DATA_W-1:0]              w_sel_data;
   logic [(2**ADDR_W)-1:0]         w_pending;
   logic [STARVE_W-1:0]            r_starve;
   logic                           r_wr_en;
   logic [ADDR_W-1:0]              r_wr_addr;
   logic [DATA_W-1:0]              r_wr_data;

   assign w_fifo_ne   = !w_empty;
   assign w_starved   = w_fifo_ne && (r_starve == c_starve_max);
   assign w_alu_ready = !reset && !w_starved;
   assign w_mem_ready = !reset && !w_full;

`ifdef WB_R0_DISCARD_EN
   assign w_push  = bus.mem_valid && w_mem_ready && (bus.mem_rd != '0);
   assign w_write = (w_grant != GRANT_NONE) && (w_sel_rd != '0);
`else
   assign w_push  = bus.mem_valid && w_mem_ready;
   assign w_write = (w_grant != GRANT_NONE);
`endif
   assign w_pop = (w_grant == GRANT_MEM);

   wb_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (w_push),
      .push_rd     (bus.mem_rd),
      .push_data   (bus.mem_data),
      .pop         (w_pop),
      .full        (w_full),
      .empty       (w_empty),
      .count       (w_count),
      .head_rd     (w_head_rd),
      .head_data   (w_head_data),
      .entry_valid (w_entry_valid),
      .entry_rd    (w_entry_rd)
   );

   // ALU wins unless the FIFO has lost STARVE_LIMIT times in a row.
   always_comb begin
      w_grant    = GRANT_NONE;
      w_sel_rd   = w_head_rd;
      w_sel_data = w_head_data;
      if (!reset) begin
         if (bus.alu_valid && !w_starved) begin
            w_grant    = GRANT_ALU;
            w_sel_rd   = bus.alu_rd;
            w_sel_data = bus.alu_data;
         end else if (w_fifo_ne) begin
            w_grant = GRANT_MEM;
         end
      end
   end

   always_comb begin
      w_pending = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (w_entry_valid[i]) begin
            w_pending[w_entry_rd[i*ADDR_W +: ADDR_W]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_starve <= '0;
      end else if (!w_fifo_ne || (w_grant == GRANT_MEM)) begin
         r_starve <= '0;
      end else if ((w_grant == GRANT_ALU) && (r_starve != c_starve_max)) begin
         r_starve <= r_starve + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= w_write;
         if (w_write) begin
            r_wr_addr <= w_sel_rd;
            r_wr_data <= w_sel_data;
         end
      end
   end

   assign bus.alu_ready    = w_alu_ready;
   assign bus.mem_ready    = w_mem_ready;
   assign bus.wr_en        = r_wr_en;
   assign bus.wr_addr      = r_wr_addr;
   assign bus.wr_data      = r_wr_data;
   assign bus.pending_mask = w_pending;
   assign bus.fifo_count   = w_count;
endmodule
`default_nettype wire
